// File: rtl/line_refill_arbiter.sv
// line_refill_arbiter: round-robin cache-line refill engine that shares
// one AXI read channel between NUM_REQ line-fill requestors.
module line_refill_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_WIDTH = 256,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic [LINE_WIDTH-1:0]     resp_data_o,
  output logic                      resp_err_o,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [ADDR_W-1:0]         ar_addr_o,
  output logic [AXI_ID_W-1:0]       ar_id_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  input  logic                      r_valid_i,
  input  logic [AXI_DATA_W-1:0]     r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i,
  output logic                      r_ready_o
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_W;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_DATA,
    S_RESP
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [PTR_W-1:0]    rr_q;
  logic [PTR_W-1:0]    grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic                err_q;
  logic [LINE_WIDTH-1:0] line_q;

  logic                gnt_ok;
  logic [PTR_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                beat_err;
  logic                unused_resp0;

  assign unused_resp0 = r_resp_i[0];

  // First valid requestor at or after the round-robin pointer.
  always_comb begin
    int idx;
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!gnt_ok && req_valid_i[idx]) begin
        gnt_ok  = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign gnt_addr =
    req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W] & LINE_MASK;

  // A beat is erroneous on SLVERR/DECERR, an early or late
  // last, or any beat beyond the end of the line.
  assign beat_err = r_resp_i[1]
                 || (r_last_i && beat_cnt_q != CNT_W'(BEATS - 1))
                 || (beat_cnt_q == CNT_W'(BEATS));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the refill sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_ok) state_d = S_AR;
      S_AR:    if (ar_ready_i) state_d = S_DATA;
      S_DATA:  if (r_valid_i && r_last_i) state_d = S_RESP;
      S_RESP:  if (resp_ready_i[grant_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant/address capture, beat aggregation and pointer advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
    end else begin
      if (state_q == S_IDLE && gnt_ok) begin
        grant_q    <= gnt_idx;
        addr_q     <= gnt_addr;
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end
      if (state_q == S_DATA && r_valid_i) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_cnt_q == CNT_W'(b))
            line_q[b*AXI_DATA_W +: AXI_DATA_W] <= r_data_i;
        end
        if (beat_cnt_q != CNT_W'(BEATS))
          beat_cnt_q <= beat_cnt_q + 1'b1;
        if (beat_err)
          err_q <= 1'b1;
      end
      if (state_q == S_RESP && resp_ready_i[grant_q]) begin
        rr_q <= (grant_q == PTR_W'(NUM_REQ - 1)) ?
                '0 : grant_q + 1'b1;
      end
    end
  end

  assign req_ready_o  = (state_q == S_IDLE && gnt_ok) ?
                        (NUM_REQ'(1) << gnt_idx) : '0;
  assign resp_valid_o = (state_q == S_RESP) ?
                        (NUM_REQ'(1) << grant_q) : '0;
  assign resp_data_o  = line_q;
  assign resp_err_o   = err_q;
  assign ar_valid_o   = (state_q == S_AR);
  assign ar_addr_o    = addr_q;
  assign ar_id_o      = AXI_ID_W'(grant_q);
  assign ar_len_o     = 8'(BEATS - 1);
  assign ar_size_o    = 3'($clog2(AXI_DATA_W / 8));
  assign ar_burst_o   = 2'b01;
  assign r_ready_o    = (state_q == S_DATA);

endmodule

// File: tb/tb_line_refill_arbiter.sv
// tb_line_refill_arbiter: table-driven refills with a response
// scoreboard, plus contention and mid-burst reset sequences.
module tb_line_refill_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int BEATS = LW / DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]   req_ready_o;
  logic [NR-1:0]   resp_valid_o;
  logic [NR-1:0]   resp_ready = '0;
  logic [LW-1:0]   resp_data_o;
  logic            resp_err_o;
  logic            ar_valid_o;
  logic            ar_ready = 1'b0;
  logic [AW-1:0]   ar_addr_o;
  logic [IW-1:0]   ar_id_o;
  logic [7:0]      ar_len_o;
  logic [2:0]      ar_size_o;
  logic [1:0]      ar_burst_o;
  logic            r_valid = 1'b0;
  logic [DW-1:0]   r_data = '0;
  logic [1:0]      r_resp = '0;
  logic            r_last = 1'b0;
  logic            r_ready_o;

  always #5 clk = ~clk;

  line_refill_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .LINE_WIDTH(LW),
    .AXI_DATA_W(DW), .AXI_ID_W(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready),
    .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid), .r_data_i(r_data),
    .r_resp_i(r_resp), .r_last_i(r_last),
    .r_ready_o(r_ready_o)
  );

  typedef struct {
    int          ch;
    logic [LW-1:0] line;
    logic        err;
  } exp_t;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] ar;
    int          nb;
    int          eb;
    int          ars;
    int          gap;
    int          rs;
    logic        err;
  } vec_t;

  exp_t          sbq[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [LW-1:0] m_line = '0;
  logic          m_err  = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] bdata(input int b,
                                          input logic [31:0] s);
    logic [7:0] v;
    v = 8'(8'h11 * (b + 1));
    return {8{v}} ^ {s, s};
  endfunction

  // Scoreboard: each accepted line must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (resp_valid_o & resp_ready) != '0) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", LW'(resp_valid_o), '0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_ch", LW'(resp_valid_o), LW'(NR'(1) << e.ch));
        chk("sb_data", resp_data_o, e.line);
        chk("sb_err", LW'(resp_err_o), LW'(e.err));
      end
    end
  end

  task automatic req_phase(input int ch, input logic [31:0] addr,
                           input logic [31:0] ea, input int ars,
                           input bit keep);
    int k;
    req_valid[ch] = 1'b1;
    req_addr[ch*AW +: AW] = addr;
    k = 0;
    @(negedge clk);
    while (req_ready_o == '0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_grant", LW'(req_ready_o), LW'(NR'(1) << ch));
    chk("idle_outputs",
        LW'({ar_valid_o, r_ready_o, resp_valid_o}), '0);
    tick;
    if (!keep) req_valid[ch] = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    chk("ar_valid", LW'(ar_valid_o), LW'(1'b1));
    chk("ar_addr", LW'(ar_addr_o), LW'(ea));
    chk("ar_id", LW'(ar_id_o), LW'(IW'(ch)));
    chk("ar_len", LW'(ar_len_o), LW'(8'd3));
    chk("ar_size", LW'(ar_size_o), LW'(3'd3));
    chk("ar_burst", LW'(ar_burst_o), LW'(2'b01));
    for (int i = 0; i < ars; i++) begin
      tick;
      @(negedge clk);
      chk("ar_hold_valid", LW'(ar_valid_o), LW'(1'b1));
      chk("ar_hold_addr", LW'(ar_addr_o), LW'(ea));
      chk("ar_hold_len", LW'(ar_len_o), LW'(8'd3));
    end
    tick;
    ar_ready = 1'b1;
    tick;
    ar_ready = 1'b0;
  endtask

  task automatic send_beat(input int b, input bit last,
                           input logic [1:0] resp,
                           input logic [31:0] seed);
    r_valid = 1'b1;
    r_data  = bdata(b, seed);
    r_resp  = resp;
    r_last  = last;
    @(negedge clk);
    chk("r_ready", LW'(r_ready_o), LW'(1'b1));
    tick;
    if (b < BEATS) m_line[b*DW +: DW] = bdata(b, seed);
    if (resp[1] || (last && b != BEATS - 1) || b >= BEATS)
      m_err = 1'b1;
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
  endtask

  task automatic resp_phase(input int ch, input int rs,
                            input logic exp_err);
    exp_t e;
    @(negedge clk);
    chk("resp_latency", LW'(resp_valid_o), LW'(NR'(1) << ch));
    chk("resp_err", LW'(resp_err_o), LW'(exp_err));
    e.ch = ch;
    e.line = m_line;
    e.err = m_err;
    sbq.push_back(e);
    for (int i = 0; i < rs; i++) begin
      tick;
      @(negedge clk);
      chk("resp_hold_valid", LW'(resp_valid_o), LW'(NR'(1) << ch));
      chk("resp_hold_data", resp_data_o, m_line);
    end
    tick;
    resp_ready[ch] = 1'b1;
    tick;
    resp_ready[ch] = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input bit keep);
    req_phase(v.ch, v.addr, v.ar, v.ars, keep);
    for (int b = 0; b < v.nb; b++) begin
      if (b > 0) repeat (v.gap) tick;
      send_beat(b, b == v.nb - 1,
                (b == v.eb) ? 2'b10 : 2'b00, v.addr);
    end
    resp_phase(v.ch, v.rs, v.err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    vec_t tv;
    vt[0] = '{0, 32'h8000_0014, 32'h8000_0000, 4, -1, 0, 0, 0, 1'b0};
    vt[1] = '{1, 32'h1234_5678, 32'h1234_5660, 4,  2, 0, 0, 0, 1'b1};
    vt[2] = '{0, 32'h0000_1040, 32'h0000_1040, 2, -1, 0, 0, 0, 1'b1};
    vt[3] = '{1, 32'h0000_20FF, 32'h0000_20E0, 6, -1, 0, 0, 0, 1'b1};
    vt[4] = '{0, 32'hDEAD_BEEF, 32'hDEAD_BEE0, 4, -1, 5, 1, 3, 1'b0};
    vt[5] = '{1, 32'h4000_003F, 32'h4000_0020, 4, -1, 2, 2, 1, 1'b0};
    vt[6] = '{0, 32'h0000_0A5A, 32'h0000_0A40, 4, -1, 0, 0, 0, 1'b0};

    rst = 1'b1;
    tick;
    @(negedge clk);
    chk("rst_req_ready", LW'(req_ready_o), '0);
    chk("rst_resp_valid", LW'(resp_valid_o), '0);
    chk("rst_ar_valid", LW'(ar_valid_o), '0);
    chk("rst_r_ready", LW'(r_ready_o), '0);
    chk("rst_resp_err", LW'(resp_err_o), '0);
    chk("rst_resp_data", resp_data_o, '0);
    tick;
    rst = 1'b0;

    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tv = '{i % 2, 32'hA000_0040 + 32'(i * 32),
             32'hA000_0040 + 32'(i * 32), 4, -1, 0, 0, 0, 1'b0};
      run_txn(tv, 1'b1);
    end
    req_valid = 2'b00;

    for (int i = 0; i < 7; i++) run_txn(vt[i], 1'b0);

    req_phase(0, 32'h0000_0100, 32'h0000_0100, 0, 1'b0);
    send_beat(0, 1'b0, 2'b00, 32'h0000_0100);
    send_beat(1, 1'b0, 2'b00, 32'h0000_0100);
    rst = 1'b1;
    tick;
    @(negedge clk);
    chk("mid_rst_req_ready", LW'(req_ready_o), '0);
    chk("mid_rst_resp_valid", LW'(resp_valid_o), '0);
    chk("mid_rst_ar_valid", LW'(ar_valid_o), '0);
    chk("mid_rst_r_ready", LW'(r_ready_o), '0);
    chk("mid_rst_resp_err", LW'(resp_err_o), '0);
    chk("mid_rst_resp_data", resp_data_o, '0);
    tick;
    req_valid = 2'b11;
    @(negedge clk);
    chk("mid_rst_rr_ptr", LW'(req_ready_o), LW'(2'b01));
    tick;
    req_valid = 2'b00;
    rst = 1'b0;
    m_line = '0;
    m_err = 1'b0;
    tv = '{1, 32'h7000_1234, 32'h7000_1220, 4, -1, 0, 0, 0, 1'b0};
    run_txn(tv, 1'b0);

    repeat (2) tick;
    chk("sb_drained", LW'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
